imem_loader: RTL and testbench

//  Upstream feeder of the 16-bit instruction memory of the 8-bit single-cycle core.

---
 rtl/imem_loader_if.sv | 19 +
 rtl/imem_loader.sv | 161 ++++++++++++++++
 tb/tb_imem_loader.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the instruction memory loader.
// master drives byte_valid/byte_data, slave (loader) drives byte_ready.
interface imem_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: packs a byte stream {N, hi, lo, ...}
// into 16-bit words written at addresses 0..N-1, holding the core
// (cpu_hold) until a load finishes cleanly.
// Ports: clk, reset (async, active high), start (pulse),
//   s (imem_loader_if.slave byte stream), imem_we/imem_addr/imem_wdata
//   (memory write), cpu_hold, done, error (sticky), word_count.
// Optional macro LOADER_CHECKSUM_EN: trailing mod-256 sum byte checked
//   after the last word; mismatch aborts with error.
module imem_loader #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      s,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_WR,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t            state, nstate;
  logic [ADDR_W-1:0] n_reg;
  logic [ADDR_W:0]   n_full;
  logic [7:0]        hi_reg, lo_reg;
  logic [TW-1:0]     timer;
  logic              loading, xfer, tout, last, take_start;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum;
  logic              sum_ok;
`endif

  // N == 0 encodes a full 2^ADDR_W word image
  assign n_full = (n_reg == '0) ?
                  {1'b1, {ADDR_W{1'b0}}} :
                  {1'b0, n_reg};

  assign last = (word_count + (ADDR_W+1)'(1)) == n_full;

`ifdef LOADER_CHECKSUM_EN
  assign loading = (state == S_LEN) || (state == S_HI) ||
                   (state == S_LO)  || (state == S_CSUM);
  assign sum_ok  = (s.byte_data == sum);
`else
  assign loading = (state == S_LEN) || (state == S_HI) ||
                   (state == S_LO);
`endif

  assign s.byte_ready = loading;
  assign xfer         = s.byte_valid && loading;
  assign tout         = loading && !xfer &&
                        (timer == TW'(TIMEOUT_CYC - 1));
  assign take_start   = start &&
                        ((state == S_IDLE) || (state == S_DONE));

  assign imem_we    = (state == S_WR);
  assign imem_wdata = {hi_reg, lo_reg};
  assign done       = (state == S_DONE);
  assign cpu_hold   = (state != S_DONE);

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE: if (start) nstate = S_LEN;
      S_LEN: begin
        if (xfer)      nstate = S_HI;
        else if (tout) nstate = S_IDLE;
      end
      S_HI: begin
        if (xfer)      nstate = S_LO;
        else if (tout) nstate = S_IDLE;
      end
      S_LO: begin
        if (xfer)      nstate = S_WR;
        else if (tout) nstate = S_IDLE;
      end
      S_WR: begin
`ifdef LOADER_CHECKSUM_EN
        nstate = last ? S_CSUM : S_HI;
`else
        nstate = last ? S_DONE : S_HI;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer)      nstate = sum_ok ? S_DONE : S_IDLE;
        else if (tout) nstate = S_IDLE;
      end
`endif
      S_DONE: if (start) nstate = S_LEN;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      imem_addr  <= '0;
      word_count <= '0;
      error      <= 1'b0;
      timer      <= '0;
      n_reg      <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      state <= nstate;

      // idle-gap counter, only meaningful while waiting for bytes
      if (!loading || xfer || tout) timer <= '0;
      else                          timer <= timer + TW'(1);

      if (take_start) begin
        error      <= 1'b0;
        word_count <= '0;
        imem_addr  <= '0;
`ifdef LOADER_CHECKSUM_EN
        sum        <= '0;
`endif
      end

      if (tout) error <= 1'b1;

      if (xfer && state == S_LEN) n_reg <= s.byte_data;
      if (xfer && state == S_HI)  hi_reg <= s.byte_data;
      if (xfer && state == S_LO)  lo_reg <= s.byte_data;
`ifdef LOADER_CHECKSUM_EN
      if (xfer && (state == S_HI || state == S_LO))
        sum <= sum + s.byte_data;
      if (xfer && state == S_CSUM && !sum_ok)
        error <= 1'b1;
`endif

      if (state == S_WR) begin
        imem_addr  <= imem_addr + ADDR_W'(1);
        word_count <= word_count + (ADDR_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, basic load, backpressure,
// async reset mid-load, timeout, IDLE byte/start overlap, wrap, checksum.
module tb_imem_loader;
  localparam int AW = 8;
  localparam int TO = 1000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          imem_we, cpu_hold, done, error;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic [AW:0]   word_count;

  imem_loader_if bus ();

  imem_loader #(
    .ADDR_W(AW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .s(bus),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int stalls = 0;
  int nw = 0;
  logic [AW-1:0] la [0:511];
  logic [15:0]   ld [0:511];

  always @(posedge clk) begin
    if (imem_we && nw < 512) begin
      la[nw] <= imem_addr;
      ld[nw] <= imem_wdata;
      nw     <= nw + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // holds byte_valid high; counts cycles byte_ready was low
  task automatic send(input logic [7:0] b);
    int k;
    k = 0;
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!bus.byte_ready) chk("send_ready", 0, 1);
    stalls += k;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base, cyc, bad;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    #1;
    chk("rst_ready", bus.byte_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_wc", word_count, 0);
    wait_cyc(2);
    reset = 1'b0;

    // basic load, valid held continuously
    base = nw;
    stalls = 0;
    pulse_start();
    send(8'h02); send(8'h12); send(8'h34);
    send(8'hAB); send(8'hCD);
`ifdef LOADER_CHECKSUM_EN
    send(8'hBE);
`endif
    idle();
    wait_cyc(3);
    chk("basic_nw", nw - base, 2);
    chk("basic_a0", la[base], 0);
    chk("basic_d0", ld[base], 16'h1234);
    chk("basic_a1", la[base+1], 1);
    chk("basic_d1", ld[base+1], 16'hABCD);
    chk("basic_done", done, 1);
    chk("basic_hold", cpu_hold, 0);
    chk("basic_wc", word_count, 2);
    chk("basic_addr", imem_addr, 2);
    chk("basic_err", error, 0);
`ifdef LOADER_CHECKSUM_EN
    chk("basic_stalls", stalls, 2);
`else
    chk("basic_stalls", stalls, 1);
`endif

    // async reset while waiting in HI after one word
    pulse_start();
    send(8'h03); send(8'h11); send(8'h22);
    idle();
    wait_cyc(2);
    chk("pre_rst_wc", word_count, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ready", bus.byte_ready, 0);
    chk("mid_rst_hold", cpu_hold, 1);
    chk("mid_rst_addr", imem_addr, 0);
    chk("mid_rst_wc", word_count, 0);
    chk("mid_rst_wdata", imem_wdata, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    base = nw;
    pulse_start();
    send(8'h01); send(8'h9A); send(8'hBC);
`ifdef LOADER_CHECKSUM_EN
    send(8'h56);
`endif
    idle();
    wait_cyc(3);
    chk("rld_nw", nw - base, 1);
    chk("rld_a0", la[base], 0);
    chk("rld_d0", ld[base], 16'h9ABC);
    chk("rld_done", done, 1);

    // timeout after silence in LO
    base = nw;
    pulse_start();
    send(8'h01); send(8'h12);
    idle();
    cyc = 0;
    while (!error && cyc < TO + 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("to_cycles", cyc, TO);
    chk("to_error", error, 1);
    chk("to_done", done, 0);
    chk("to_hold", cpu_hold, 1);
    chk("to_ready", bus.byte_ready, 0);
    chk("to_nw", nw - base, 0);

    // byte_valid in IDLE: ignored, error stays sticky
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hFF;
    wait_cyc(3);
    chk("idle_ready", bus.byte_ready, 0);
    chk("idle_nw", nw - base, 0);
    chk("idle_err", error, 1);

    // start with byte_valid high: FF must not become N; then N=0 wrap
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.byte_data = 8'h00;
    chk("st_err_clr", error, 0);
    base = nw;
    stalls = 0;
    for (int i = 0; i < 512; i++) send(8'(i));
`ifdef LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    idle();
    wait_cyc(3);
    chk("wrap_nw", nw - base, 256);
    bad = 0;
    for (int j = 0; j < 256; j++) begin
      if (la[base+j] !== 8'(j) ||
          ld[base+j] !== {8'(2*j), 8'(2*j+1)})
        bad++;
    end
    chk("wrap_data", bad, 0);
    chk("wrap_wc", word_count, 256);
    chk("wrap_addr", imem_addr, 0);
    chk("wrap_done", done, 1);
`ifdef LOADER_CHECKSUM_EN
    chk("wrap_stalls", stalls, 256);
`else
    chk("wrap_stalls", stalls, 255);
`endif

`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    send(8'h01); send(8'h12); send(8'h34); send(8'h46);
    idle();
    wait_cyc(3);
    chk("cs_ok_done", done, 1);
    chk("cs_ok_err", error, 0);
    pulse_start();
    send(8'h01); send(8'h12); send(8'h34); send(8'h47);
    idle();
    wait_cyc(3);
    chk("cs_bad_err", error, 1);
    chk("cs_bad_done", done, 0);
    chk("cs_bad_hold", cpu_hold, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
